// File: rtl/f36m_frob_mult.sv
// Frobenius-power multiplier c = a^(3^n) * b over GF(3^6), trits packed 2 bits each (0,1,2).
// Optional macro F36M_FROB_BYPASS_EN adds mult_en; latched 0 returns a^(3^n) without the multiply.

`ifndef W6
`define W6 11
`endif

package f36m_pkg;
    localparam int unsigned NT = (`W6 + 1) / 2;
    typedef logic [`W6:0] elem_t;

    function automatic logic [1:0] tadd(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    function automatic logic [1:0] tmul(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] r;
        r = 2'd0;
        if (x == 2'd1) r = y;
        else if (x == 2'd2) r = (y == 2'd1) ? 2'd2 : ((y == 2'd2) ? 2'd1 : 2'd0);
        return r;
    endfunction

    // Modulus x^6 + 2x^4 + x^2 + 2x + 2, so x^6 folds back as x^4 + 2x^2 + x + 1.
    function automatic elem_t f_cube(input elem_t x);
        logic [1:0] p [3*NT-2];
        elem_t      r;
        for (int unsigned i = 0; i < 3*NT-2; i++) p[i] = 2'd0;
        for (int unsigned i = 0; i < NT; i++) p[3*i] = x[2*i +: 2];
        for (int unsigned d = 3*NT-3; d >= NT; d--) begin
            p[d-2] = tadd(p[d-2], p[d]);
            p[d-4] = tadd(p[d-4], tmul(p[d], 2'd2));
            p[d-5] = tadd(p[d-5], p[d]);
            p[d-6] = tadd(p[d-6], p[d]);
        end
        r = '0;
        for (int unsigned i = 0; i < NT; i++) r[2*i +: 2] = p[i];
        return r;
    endfunction

    function automatic elem_t f_mulx(input elem_t x);
        elem_t      r;
        logic [1:0] t;
        t = x[2*(NT-1) +: 2];
        r = {x[2*(NT-1)-1:0], 2'b00};
        r[8 +: 2] = tadd(r[8 +: 2], t);
        r[4 +: 2] = tadd(r[4 +: 2], tmul(t, 2'd2));
        r[2 +: 2] = tadd(r[2 +: 2], t);
        r[0 +: 2] = tadd(r[0 +: 2], t);
        return r;
    endfunction

    function automatic elem_t f_mac(input elem_t acc, input elem_t x, input logic [1:0] s);
        elem_t r;
        for (int unsigned i = 0; i < NT; i++) r[2*i +: 2] = tadd(acc[2*i +: 2], tmul(x[2*i +: 2], s));
        return r;
    endfunction
endpackage

module f36m_cubic #(
    parameter int unsigned LAT = 2
) (
    input  logic         clk,
    input  logic [`W6:0] a,
    output logic [`W6:0] c
);
    import f36m_pkg::*;

    logic [`W6:0] r_pipe [LAT];

    always_ff @(posedge clk) begin
        r_pipe[0] <= f_cube(a);
        for (int unsigned i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end

    assign c = r_pipe[LAT-1];
endmodule

module f36m_mult (
    input  logic         clk,
    input  logic         reset,
    input  logic [`W6:0] a,
    input  logic [`W6:0] b,
    output logic [`W6:0] c,
    output logic         done
);
    import f36m_pkg::*;

    // Steps 0..2 are the internal reset delay; steps 3..8 consume b MSB-first (Horner).
    logic [3:0]   r_step;
    logic [`W6:0] r_acc;
    logic [3:0]   w_idx;
    logic [1:0]   w_bt;

    always_comb begin
        w_idx = 4'd8 - r_step;
        w_bt  = 2'd0;
        for (int unsigned j = 0; j < NT; j++)
            if (w_idx == 4'(j)) w_bt = b[2*j +: 2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step <= '0;
            r_acc  <= '0;
        end else if (r_step != 4'd9) begin
            r_step <= r_step + 4'd1;
            if (r_step >= 4'd3) r_acc <= f_mac(f_mulx(r_acc), a, w_bt);
        end
    end

    assign c    = r_acc;
    assign done = (r_step == 4'd9);
endmodule

module f36m_frob_mult #(
    parameter int unsigned CUBE_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [`W6:0] a,
    input  logic [`W6:0] b,
    input  logic [3:0]   n,
`ifdef F36M_FROB_BYPASS_EN
    input  logic         mult_en,
`endif
    output logic [`W6:0] c,
    output logic         done
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CUBE   = 3'd1;
    localparam logic [2:0] CWAIT  = 3'd2;
    localparam logic [2:0] MSTART = 3'd3;
    localparam logic [2:0] MWAIT  = 3'd4;
    localparam logic [2:0] FIN    = 3'd5;
    localparam int unsigned WW = (CUBE_LAT > 1) ? $clog2(CUBE_LAT) : 1;

    logic [2:0]    r_state;
    logic [`W6:0]  r_t;
    logic [`W6:0]  r_bl;
    logic [`W6:0]  r_c;
    logic [3:0]    r_cnt;
    logic [WW-1:0] r_wait;
    logic [1:0]    r_ign;
    logic          r_rst_q;
    logic [`W6:0]  w_cube;
    logic [`W6:0]  w_mc;
    logic          w_mdone;
    logic          w_mrst;
    logic          w_men;

`ifdef F36M_FROB_BYPASS_EN
    logic r_men;
    always_ff @(posedge clk) begin
        if (reset) r_men <= mult_en;
    end
    assign w_men = r_men;
`else
    assign w_men = 1'b1;
`endif

    // Re-reset the multiplier right after a block reset so an aborted product is discarded.
    assign w_mrst = ((r_state == MSTART) || r_rst_q) && w_men;

    f36m_cubic #(.LAT(CUBE_LAT)) u_cubic (
        .clk (clk),
        .a   (r_t),
        .c   (w_cube)
    );

    f36m_mult u_mult (
        .clk   (clk),
        .reset (w_mrst),
        .a     (r_t),
        .b     (r_bl),
        .c     (w_mc),
        .done  (w_mdone)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_t     <= a;
            r_bl    <= b;
            r_cnt   <= n;
            r_wait  <= '0;
            r_ign   <= '0;
            r_rst_q <= 1'b1;
            r_state <= (n != 4'd0) ? CUBE : MSTART;
        end else begin
            r_rst_q <= 1'b0;
            case (r_state)
                CUBE: begin
                    r_wait  <= WW'(CUBE_LAT - 1);
                    r_state <= CWAIT;
                end
                CWAIT: begin
                    if (r_wait == '0) begin
                        r_t     <= w_cube;
                        r_cnt   <= r_cnt - 4'd1;
                        r_state <= (r_cnt != 4'd1) ? CUBE : MSTART;
                    end else begin
                        r_wait <= r_wait - WW'(1);
                    end
                end
                MSTART: begin
                    r_ign <= '0;
                    if (w_men) begin
                        r_state <= MWAIT;
                    end else begin
                        r_c     <= r_t;
                        r_state <= FIN;
                    end
                end
                MWAIT: begin
                    if (r_ign != 2'd3) begin
                        r_ign <= r_ign + 2'd1;
                    end else if (w_mdone) begin
                        r_c     <= w_mc;
                        r_state <= FIN;
                    end
                end
                FIN:     r_state <= FIN;
                IDLE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign c    = r_c;
    assign done = (r_state == FIN);
endmodule

// File: doc/f36m_frob_mult.md
F36M_FROB_MULT -- requirements
Module: f36m_frob_mult

Interface
REQ-001 Parameter: CUBE_LAT, default 2, clock cycles from f36m_cubic input change to valid registered output.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset that also starts a new operation.
REQ-004 a  input  `W6+1  GF(3^6M) base operand, packed {a2,a1,a0}.
REQ-005 b  input  `W6+1  GF(3^6M) multiplier operand, packed {b2,b1,b0}.
REQ-006 n  input  4  Frobenius exponent count k, 0..15.
REQ-007 c  output  `W6+1  result a^(3^k) * b.
REQ-008 done  output  1  high when c is valid; held until next reset.
REQ-009 mult_en  input  1  present only with F36M_FROB_BYPASS_EN (see Configuration).

Function
REQ-010 The block SHALL compute c = a^(3^k) * b in GF(3^6M) by k sequential cubings followed by one f36m_mult product.
REQ-011 On the reset cycle the block SHALL latch a into the working register t, b into register bl, n into down-counter cnt; inputs are don't-care afterwards.
REQ-012 FSM states SHALL be IDLE, CUBE, CWAIT, MSTART, MWAIT, FIN.
REQ-013 Reset SHALL force CUBE if n != 0, else MSTART.
REQ-014 CUBE: drive t into one f36m_cubic instance, load wait counter with CUBE_LAT-1, go to CWAIT.
REQ-015 CWAIT: decrement wait counter; at zero, load t with cubic output, decrement cnt; go to CUBE if cnt != 1 before decrement, else MSTART.
REQ-016 Each cubing step SHALL take exactly CUBE_LAT+1 cycles.
REQ-017 MSTART: assert the f36m_mult instance reset for exactly one cycle with operands t, bl held stable; go to MWAIT.
REQ-018 MWAIT: ignore multiplier done for the first 3 cycles (its internal reset delay); thereafter on multiplier done high, register its c into c, go to FIN.
REQ-019 FIN: done SHALL be 1, c stable; remain in FIN until reset; IDLE reached only after power-up before first reset.
REQ-020 Latency from reset deassertion to done SHALL be k*(CUBE_LAT+1) + 1 + T_mult + 1 cycles, T_mult being the multiplier's reset-to-done count.
REQ-021 Operands t and bl SHALL NOT change while the multiplier is busy.
REQ-022 Reset asserted in any state, including mid-cube or mid-multiply, SHALL abort the operation, relatch inputs and restart; no partial result SHALL reach c.

Reset
REQ-023 On reset done SHALL be 0 at the next edge; c SHALL be held at its previous value (not cleared) until the new result is written.
REQ-024 Multiplier reset SHALL be asserted in the cycle following any block reset to discard an in-flight product.
REQ-025 Before the first reset, done SHALL be treated as undefined by users; the FSM SHALL power up in IDLE in simulation.

Configuration
REQ-026 Macro F36M_FROB_BYPASS_EN: when defined, mult_en port exists and is latched on reset; if latched 0, CWAIT exit to MSTART SHALL instead write t to c and go to FIN (latency k*(CUBE_LAT+1)+1); if 1, behaviour per REQ-017..020.
REQ-027 Without F36M_FROB_BYPASS_EN, mult_en port is absent and the multiply is always performed.

Verification
REQ-028 n=0, a=X random, b=GF(3^6M) unity -> c==X, done at cycle 2+T_mult after reset.
REQ-029 n=1, a=X, b=unity -> c equals f36m_cubic(X) reference output, done at cycle (CUBE_LAT+1)+2+T_mult.
REQ-030 n=15, a=X, b=Y -> c equals 15 model cubings of X times Y; latency 15*(CUBE_LAT+1)+2+T_mult.
REQ-031 a=0, n=5, b=Y -> c==0; a=X, b=0 -> c==0.
REQ-032 Reset reasserted in MWAIT with new n=2, a=Z -> done stays 0, final c equals Z^9*b, old product never appears on c.
REQ-033 With F36M_FROB_BYPASS_EN, mult_en=0, n=3, a=X -> c==X^27, done at cycle 3*(CUBE_LAT+1)+1; multiplier reset never asserted.
